// File: rtl/game_pkg.sv
// Shared types and constants for the ocean-game flow controller.
package game_pkg;

  // One-hot game phase encoding
  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_PLAY = 4'b0010,
    ST_HIT  = 4'b0100,
    ST_OVER = 4'b1000
  } state_e;

  localparam logic [7:0]  SCORE_MAX = 8'd255;

  localparam int unsigned LIVES_DEF      = 3;
  localparam int unsigned MOVE_DIV_DEF   = 2;
  localparam int unsigned HIT_FRAMES_DEF = 60;

  localparam int unsigned DIV_W   = 4;
  localparam int unsigned HIT_W   = 8;
  localparam int unsigned LIVES_W = 2;
  localparam int unsigned SCORE_W = 8;

endpackage

// File: rtl/frame_divider.sv
// Frame-tick divider: counts qualified ticks and emits a registered one-cycle
// pulse on the cycle after the terminal tick.
module frame_divider
  import game_pkg::*;
#(
  parameter int unsigned DIV = MOVE_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_tick,
  output logic o_pulse
);

  localparam logic [DIV_W-1:0] TERM = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] r_cnt;
  logic             r_pulse;

  // Count ticks; wrap at terminal count and fire the pulse for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (i_clr) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        if (r_cnt == TERM) begin
          r_cnt   <= '0;
          r_pulse <= 1'b1;
        end else begin
          r_cnt <= r_cnt + DIV_W'(1);
        end
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: idle/play/hit/over phases, lives, score and gating of
// object motion. Every output is decoded from registers only.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned LIVES      = LIVES_DEF,
  parameter int unsigned MOVE_DIV   = MOVE_DIV_DEF,
  parameter int unsigned HIT_FRAMES = HIT_FRAMES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         frame_tick,
  input  logic         hit_shark,
  input  logic         hit_bottle,
  output logic         move_en,
  output logic         obj_reset,
  output logic         blank_player,
  output logic [1:0]   lives,
  output logic [7:0]   score,
  output logic         q_IDLE,
  output logic         q_PLAY,
  output logic         q_HIT,
  output logic         q_OVER
);

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [HIT_W-1:0]   HIT_LAST   = HIT_W'(HIT_FRAMES - 1);

  state_e             r_state;
  logic [LIVES_W-1:0] r_lives;
  logic [SCORE_W-1:0] r_score;
  logic [HIT_W-1:0]   r_hit_cnt;
  logic               r_obj_pulse;
  logic               r_start_q;

  state_e             w_state_nxt;
  logic [LIVES_W-1:0] w_lives_nxt;
  logic [SCORE_W-1:0] w_score_nxt;
  logic [HIT_W-1:0]   w_hit_cnt_nxt;
  logic               w_obj_pulse_nxt;
  logic               w_div_clr;
  logic               w_div_tick;
  logic               w_start_rise;
  logic               w_move_pulse;

  assign w_start_rise = start & ~r_start_q;

  // State and game-data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_lives     <= LIVES_INIT;
      r_score     <= '0;
      r_hit_cnt   <= '0;
      r_obj_pulse <= 1'b0;
      r_start_q   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lives     <= w_lives_nxt;
      r_score     <= w_score_nxt;
      r_hit_cnt   <= w_hit_cnt_nxt;
      r_obj_pulse <= w_obj_pulse_nxt;
      r_start_q   <= start;
    end
  end

  // Next-state, lives/score update and divider control
  always_comb begin
    w_state_nxt     = r_state;
    w_lives_nxt     = r_lives;
    w_score_nxt     = r_score;
    w_hit_cnt_nxt   = r_hit_cnt;
    w_obj_pulse_nxt = 1'b0;
    w_div_clr       = 1'b0;
    w_div_tick      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_rise) begin
          w_state_nxt = ST_PLAY;
          w_lives_nxt = LIVES_INIT;
          w_score_nxt = '0;
          w_div_clr   = 1'b1;
        end
      end
      ST_PLAY: begin
        if (hit_shark) begin
          // Shark wins over bottle and over a dividing tick
          if (r_lives == LIVES_W'(1)) begin
            w_lives_nxt = '0;
            w_state_nxt = ST_OVER;
          end else begin
            w_lives_nxt   = r_lives - LIVES_W'(1);
            w_state_nxt   = ST_HIT;
            w_hit_cnt_nxt = '0;
          end
        end else begin
          w_div_tick = frame_tick;
          if (hit_bottle && (r_score != SCORE_MAX)) begin
            w_score_nxt = r_score + SCORE_W'(1);
          end
        end
      end
      ST_HIT: begin
        if (frame_tick) begin
          w_hit_cnt_nxt = r_hit_cnt + HIT_W'(1);
          if (r_hit_cnt == HIT_LAST) begin
            w_state_nxt     = ST_PLAY;
            w_div_clr       = 1'b1;
            w_obj_pulse_nxt = 1'b1;
          end
        end
      end
      ST_OVER: begin
        if (w_start_rise) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  frame_divider #(
    .DIV (MOVE_DIV)
  ) u_move_div (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_div_clr),
    .i_tick  (w_div_tick),
    .o_pulse (w_move_pulse)
  );

  assign q_IDLE       = (r_state == ST_IDLE);
  assign q_PLAY       = (r_state == ST_PLAY);
  assign q_HIT        = (r_state == ST_HIT);
  assign q_OVER       = (r_state == ST_OVER);
  assign move_en      = w_move_pulse;
  assign obj_reset    = q_IDLE | q_OVER | r_obj_pulse;
  assign blank_player = q_HIT & r_hit_cnt[3];
  assign lives        = r_lives;
  assign score        = r_score;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed scenarios plus random
// stimulus, all compared cycle by cycle against a behavioural game model.
module tb_game_sequencer;

  localparam int T_LIVES = 3;
  localparam int T_DIV   = 2;
  localparam int T_HIT   = 60;

  logic       clk;
  logic       rst;
  logic       start;
  logic       frame_tick;
  logic       hit_shark;
  logic       hit_bottle;
  logic       move_en;
  logic       obj_reset;
  logic       blank_player;
  logic [1:0] lives;
  logic [7:0] score;
  logic       q_IDLE;
  logic       q_PLAY;
  logic       q_HIT;
  logic       q_OVER;

  int checks = 0;
  int errors = 0;

  game_sequencer #(
    .LIVES      (T_LIVES),
    .MOVE_DIV   (T_DIV),
    .HIT_FRAMES (T_HIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .frame_tick   (frame_tick),
    .hit_shark    (hit_shark),
    .hit_bottle   (hit_bottle),
    .move_en      (move_en),
    .obj_reset    (obj_reset),
    .blank_player (blank_player),
    .lives        (lives),
    .score        (score),
    .q_IDLE       (q_IDLE),
    .q_PLAY       (q_PLAY),
    .q_HIT        (q_HIT),
    .q_OVER       (q_OVER)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural game model ----------------
  typedef enum int {P_IDLE, P_PLAY, P_HIT, P_OVER} phase_e;

  phase_e m_phase;
  int     m_lives;
  int     m_score;
  int     m_frames;
  int     m_hitframes;
  bit     m_move;
  bit     m_objpulse;
  bit     m_start_prev;

  function automatic void model_step(input bit r, input bit s, input bit ft,
                                     input bit hs, input bit hb);
    bit rise;
    if (r) begin
      m_phase = P_IDLE; m_lives = T_LIVES; m_score = 0; m_frames = 0;
      m_hitframes = 0; m_move = 0; m_objpulse = 0; m_start_prev = 0;
      return;
    end
    rise = s && !m_start_prev;
    m_start_prev = s;
    m_move = 0;
    m_objpulse = 0;
    case (m_phase)
      P_IDLE: if (rise) begin
        m_phase = P_PLAY; m_lives = T_LIVES; m_score = 0; m_frames = 0;
      end
      P_PLAY: begin
        if (hs) begin
          m_lives = m_lives - 1;
          if (m_lives == 0) m_phase = P_OVER;
          else begin m_phase = P_HIT; m_hitframes = 0; end
        end else begin
          if (ft) begin
            m_frames = m_frames + 1;
            if (m_frames == T_DIV) begin m_frames = 0; m_move = 1; end
          end
          if (hb && m_score < 255) m_score = m_score + 1;
        end
      end
      P_HIT: if (ft) begin
        m_hitframes = m_hitframes + 1;
        if (m_hitframes == T_HIT) begin
          m_phase = P_PLAY; m_frames = 0; m_objpulse = 1;
        end
      end
      default: if (rise) m_phase = P_IDLE;
    endcase
  endfunction

  // {idle,play,hit,over,move_en,obj_reset,blank,lives[1:0],score[7:0]}
  function automatic logic [16:0] model_out();
    logic blank;
    logic objr;
    blank = (m_phase == P_HIT) && (((m_hitframes / 8) % 2) == 1);
    objr  = (m_phase == P_IDLE) || (m_phase == P_OVER) || m_objpulse;
    return {m_phase == P_IDLE, m_phase == P_PLAY, m_phase == P_HIT,
            m_phase == P_OVER, m_move, objr, blank, 2'(m_lives), 8'(m_score)};
  endfunction

  function automatic logic [16:0] dut_out();
    return {q_IDLE, q_PLAY, q_HIT, q_OVER, move_en, obj_reset, blank_player,
            lives, score};
  endfunction

  // Apply one cycle of inputs, advance the model, settle after the edge
  task automatic drive(input bit r, input bit s, input bit ft, input bit hs,
                       input bit hb);
    rst = r; start = s; frame_tick = ft; hit_shark = hs; hit_bottle = hb;
    @(posedge clk);
    model_step(r, s, ft, hs, hb);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 1, 1, 1);
    checks++;
    if (dut_out() !== model_out()) begin
      errors++;
      $display("FAIL reset_model: got %h expected %h", dut_out(), model_out());
    end
    checks++;
    if ({q_IDLE, q_PLAY, q_HIT, q_OVER, move_en, obj_reset, blank_player, lives, score}
        !== {4'b1000, 1'b0, 1'b1, 1'b0, 2'd3, 8'd0}) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", dut_out(),
               {4'b1000, 1'b0, 1'b1, 1'b0, 2'd3, 8'd0});
    end
  endtask

  task automatic test_start_edge();
    int entries;
    bit prev_play;
    entries = 0;
    prev_play = q_PLAY;
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 0, 0);
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL start_cycle%0d: got %h expected %h", i, dut_out(), model_out());
      end
      if (q_PLAY && !prev_play) entries++;
      prev_play = q_PLAY;
    end
    checks++;
    if (entries !== 1) begin
      errors++;
      $display("FAIL start_once: got %0d transitions expected 1", entries);
    end
    checks++;
    if ({q_PLAY, lives, score, obj_reset} !== {1'b1, 2'd3, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL start_state: got play=%b lives=%0d score=%0d objr=%b expected 1/3/0/0",
               q_PLAY, lives, score, obj_reset);
    end
  endtask

  task automatic test_move_div();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 2; k++) begin
        drive(0, 0, (k == 0), 0, 0);
        checks++;
        if (dut_out() !== model_out()) begin
          errors++;
          $display("FAIL move_tick%0d_%0d: got %h expected %h", i, k, dut_out(), model_out());
        end
        if (move_en) pulses++;
      end
    end
    checks++;
    if (pulses !== 3) begin
      errors++;
      $display("FAIL move_count: got %0d expected 3", pulses);
    end
  endtask

  task automatic test_score_sat();
    for (int i = 0; i < 300; i++) begin
      drive(0, 0, 0, 0, 1);
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL score_step%0d: got %h expected %h", i, dut_out(), model_out());
      end
    end
    checks++;
    if (score !== 8'd255) begin
      errors++;
      $display("FAIL score_sat: got %0d expected 255", score);
    end
    drive(0, 0, 0, 1, 1);
    checks++;
    if ({lives, score, q_HIT} !== {2'd2, 8'd255, 1'b1}) begin
      errors++;
      $display("FAIL shark_bottle: got lives=%0d score=%0d hit=%b expected 2/255/1",
               lives, score, q_HIT);
    end
  endtask

  task automatic test_hit_phase();
    int toggles;
    bit prev_blank;
    toggles = 0;
    prev_blank = blank_player;
    for (int i = 0; i < T_HIT; i++) begin
      drive(0, 0, 1, 1, 1);
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL hit_tick%0d: got %h expected %h", i, dut_out(), model_out());
      end
      if (blank_player != prev_blank) toggles++;
      prev_blank = blank_player;
    end
    checks++;
    if (toggles !== 8) begin
      errors++;
      $display("FAIL blink_toggles: got %0d expected 8", toggles);
    end
    checks++;
    if ({q_PLAY, obj_reset, lives} !== {1'b1, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL hit_exit: got play=%b objr=%b lives=%0d expected 1/1/2",
               q_PLAY, obj_reset, lives);
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (obj_reset !== 1'b0) begin
      errors++;
      $display("FAIL objr_pulse_width: got %b expected 0", obj_reset);
    end
  endtask

  task automatic test_game_over();
    int pulses;
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < T_HIT; i++) begin
      drive(0, 0, 1, 0, 0);
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL over_hit%0d: got %h expected %h", i, dut_out(), model_out());
      end
    end
    drive(0, 0, 1, 1, 0);
    checks++;
    if ({q_OVER, lives, obj_reset} !== {1'b1, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL game_over: got over=%b lives=%0d objr=%b expected 1/0/1",
               q_OVER, lives, obj_reset);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 0, 0);
      if (move_en) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL over_no_move: got %0d pulses expected 0", pulses);
    end
    drive(0, 1, 0, 0, 0);
    checks++;
    if ({q_IDLE, score} !== {1'b1, 8'd255}) begin
      errors++;
      $display("FAIL over_to_idle: got idle=%b score=%0d expected 1/255", q_IDLE, score);
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_rst_mid_hit();
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) drive(0, 0, 1, 0, 0);
    checks++;
    if (dut_out() !== model_out()) begin
      errors++;
      $display("FAIL pre_rst_hit: got %h expected %h", dut_out(), model_out());
    end
    drive(1, 0, 1, 1, 1);
    checks++;
    if ({q_IDLE, lives, score, blank_player, move_en} !== {1'b1, 2'd3, 8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_hit: got idle=%b lives=%0d score=%0d blank=%b move=%b expected 1/3/0/0/0",
               q_IDLE, lives, score, blank_player, move_en);
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit s;
    int bad;
    s = 0;
    bad = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) s = ~s;
      drive(($urandom_range(0, 999) == 0), s, ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 60) == 0), ($urandom_range(0, 5) == 0));
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_cycle%0d: got %h expected %h", i, dut_out(), model_out());
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; frame_tick = 1'b0; hit_shark = 1'b0; hit_bottle = 1'b0;
    test_reset();
    test_start_edge();
    test_move_div();
    test_score_sat();
    test_hit_phase();
    test_game_over();
    test_rst_mid_hit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Top-level game-flow controller for the VGA ocean game. It sequences the object-motion datapath: it gates sprite movement to a frame-rate divider and holds or re-initialises object positions. It also tracks lives and bottle score, and runs the idle/play/hit/game-over phases. It sits between the display timing (frame tick), the collision detectors and the object/rgb datapath.

Parameters:
LIVES, 3, lives loaded at game start; legal range 1..3.
MOVE_DIV, 2, frames per movement step; legal range 1..15.
HIT_FRAMES, 60, frames of invulnerability/blink after a shark hit; legal range 1..255.

Ports:
clk  in  1  system clock
rst  in  1  reset
start  in  1  debounced start button, level
frame_tick  in  1  one-cycle pulse per displayed frame, from display timing
hit_shark  in  1  one-cycle pulse: player overlapped a shark
hit_bottle  in  1  one-cycle pulse: player overlapped a bottle
move_en  out  1  one-cycle pulse: object datapath advances one step
obj_reset  out  1  high: object datapath loads initial positions
blank_player  out  1  high: rgb mux suppresses player sprite
lives  out  2  remaining lives
score  out  8  bottles collected, saturating
q_IDLE, q_PLAY, q_HIT, q_OVER  out  1 each  one-hot state flags

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - lives = LIVES, score = 0.
  - move_en = 0, blank_player = 0.
  - obj_reset = 1, because it is decoded from IDLE.
  - All counters = 0, start_q = 0.
- All outputs derive from registers only. No combinational path from any input to any output.
- start edge: start_q registers start each cycle. start_rise = start & ~start_q. Only start_rise causes transitions, so a held button fires once.
- State register is one-hot, 4 bits: IDLE, PLAY, HIT, OVER. An illegal encoding goes to IDLE on the next clk.
- IDLE:
  - obj_reset = 1, move_en = 0.
  - start_rise -> PLAY. On the same edge: lives <= LIVES, score <= 0, div_cnt <= 0.
- PLAY:
  - On frame_tick: if div_cnt == MOVE_DIV-1, then div_cnt <= 0 and move_en is high for exactly the next cycle. Otherwise div_cnt increments.
  - hit_shark has priority. If lives == 1: lives <= 0 and go to OVER. Otherwise: lives decrements, go to HIT, hit_cnt <= 0.
  - hit_bottle without hit_shark in the same cycle: score <= score + 1, saturating at 255.
  - hit_shark and hit_bottle together: the bottle is ignored.
  - hit_shark together with a dividing frame_tick: the transition wins and no move_en is produced.
- HIT:
  - move_en = 0. hit_shark and hit_bottle are ignored (invulnerable).
  - Each frame_tick increments hit_cnt.
  - blank_player = hit_cnt[3], blinking every 8 frames.
  - When frame_tick arrives with hit_cnt == HIT_FRAMES-1: go to PLAY, div_cnt <= 0, and obj_reset pulses high for exactly one cycle (the first PLAY cycle).
- OVER:
  - obj_reset = 1, move_en = 0, blank_player = 0.
  - lives holds 0 and score holds its final value.
  - start_rise -> IDLE, with score preserved until the next IDLE->PLAY.
- rst mid-game: all state returns to reset values on the same edge, overriding any simultaneous input.
- start_rise in PLAY or HIT is ignored.
- Latency:
  - move_en follows the qualifying frame_tick by 1 cycle.
  - Flags follow the causing input by 1 cycle.

Decomposition:
- Shared package game_pkg holds:
  - the one-hot state localparams ST_IDLE=4'b0001, ST_PLAY=4'b0010, ST_HIT=4'b0100, ST_OVER=4'b1000;
  - the SCORE_MAX=8'd255 constant;
  - the default LIVES, MOVE_DIV and HIT_FRAMES.
- One natural sub-module, frame_divider: a frame_tick counter with clear, terminal count and registered one-cycle pulse output. Instantiate it for move_en.
- The HIT-phase hit_cnt stays inline in the FSM.

Test Plan:
- rst, then start held high for 10 cycles -> exactly one IDLE->PLAY transition; q_PLAY=1, lives=3, score=0, obj_reset=0.
- PLAY with MOVE_DIV=2 and 6 frame_ticks -> exactly 3 move_en pulses, each 1 cycle wide, each 1 cycle after the 2nd, 4th and 6th tick.
- 300 hit_bottle pulses in PLAY -> score reaches 255 and stays 255. One cycle with hit_shark and hit_bottle together -> lives 3->2, score unchanged, q_HIT=1.
- In HIT, inject hit_shark during 60 frame_ticks -> lives stays 2. blank_player toggles every 8 ticks. After tick 60: q_PLAY=1, with a one-cycle obj_reset pulse.
- Three shark hits, each separated by a full HIT phase -> after the 3rd hit lives=0, q_OVER=1, obj_reset=1, no further move_en. Then start_rise -> q_IDLE=1.
- rst asserted mid-HIT together with frame_tick -> next cycle q_IDLE=1, lives=3, score=0, blank_player=0, move_en=0.
